// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer: FSM state encoding,
// window kinds, default window lengths and the flag-producer opcodes.
package pipe_hazard_sequencer_pkg;

  localparam int unsigned CntW = 3;

  localparam int unsigned DefBrFlushCyc   = 2;
  localparam int unsigned DefLdStallCyc   = 1;
  localparam int unsigned DefFlagStallCyc = 1;

  // Flag-producing opcodes whose writeback raises flag_hzd.
  localparam logic [3:0] OpSetf = 4'hC;
  localparam logic [3:0] OpCplf = 4'hD;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StLdStall   = 2'd1,
    StFlagStall = 2'd2,
    StBrFlush   = 2'd3
  } hzd_state_e;

  typedef enum logic [1:0] {
    WinNone  = 2'd0,
    WinStall = 2'd1,
    WinBr    = 2'd2
  } hzd_win_e;

  // Counter preload for an N-cycle window: cycle 1 is served from IDLE.
  function automatic logic [CntW-1:0] win_load(input int unsigned n);
    int unsigned m;
    m = (n > 1) ? n - 2 : 0;
    return m[CntW-1:0];
  endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_window_cnt.sv
// Loadable down-counter with zero flag that times a hazard window.
module hzd_window_cnt #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] cnt,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline hazard sequencer: turns branch/load-use/flag hazard requests into timed
// stall/flush windows. Optional perf counters are enabled by HZD_PERF_CNT_EN.
module pipe_hazard_sequencer
  import pipe_hazard_sequencer_pkg::*;
#(
  parameter int unsigned BR_FLUSH_CYC   = DefBrFlushCyc,
  parameter int unsigned LD_STALL_CYC   = DefLdStallCyc,
  parameter int unsigned FLAG_STALL_CYC = DefFlagStallCyc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_en,
  input  logic        load_use_hzd,
  input  logic        flag_hzd,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        flush_F,
  output logic        flush_D,
  output logic        flush_E,
  output logic        alu_en_out,
  output logic        busy
`ifdef HZD_PERF_CNT_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] stall_cyc_cnt,
  output logic [15:0] flush_cyc_cnt
`endif
);

  hzd_state_e      state_q, state_d;
  hzd_win_e        win;
  logic            cnt_load;
  logic            cnt_dec;
  logic [CntW-1:0] cnt_val;
  logic [CntW-1:0] cnt;
  logic            cnt_zero;

  hzd_window_cnt #(
    .Width(CntW)
  ) u_window_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the window kind driven this cycle.
  always_comb begin
    state_d  = state_q;
    win      = WinNone;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (branch_en) begin
          win = WinBr;
          if (BR_FLUSH_CYC > 1) begin
            state_d  = StBrFlush;
            cnt_load = 1'b1;
            cnt_val  = win_load(BR_FLUSH_CYC);
          end
        end else if (flag_hzd) begin
          win = WinStall;
          if (FLAG_STALL_CYC > 1) begin
            state_d  = StFlagStall;
            cnt_load = 1'b1;
            cnt_val  = win_load(FLAG_STALL_CYC);
          end
        end else if (load_use_hzd) begin
          win = WinStall;
          if (LD_STALL_CYC > 1) begin
            state_d  = StLdStall;
            cnt_load = 1'b1;
            cnt_val  = win_load(LD_STALL_CYC);
          end
        end
      end
      StLdStall, StFlagStall: begin
        // A taken branch pre-empts the stall and restarts as a full branch window.
        if (branch_en) begin
          win = WinBr;
          if (BR_FLUSH_CYC > 1) begin
            state_d  = StBrFlush;
            cnt_load = 1'b1;
            cnt_val  = win_load(BR_FLUSH_CYC);
          end else begin
            state_d = StIdle;
          end
        end else begin
          win = WinStall;
          if (cnt_zero) begin
            state_d = StIdle;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      StBrFlush: begin
        win = WinBr;
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; reset forces everything low, including alu_en_out.
  always_comb begin
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    stall_E    = 1'b0;
    flush_F    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    alu_en_out = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      unique case (win)
        WinStall: begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
          busy    = 1'b1;
        end
        WinBr: begin
          flush_F = 1'b1;
          flush_D = 1'b1;
          stall_E = 1'b1;
          busy    = 1'b1;
        end
        default: alu_en_out = 1'b1;
      endcase
    end
  end

`ifdef HZD_PERF_CNT_EN
  logic [15:0] stall_cyc_q, flush_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
    end else if (cnt_clr) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      if (stall_F && flush_E && (stall_cyc_q != 16'hFFFF)) begin
        stall_cyc_q <= stall_cyc_q + 16'd1;
      end
      if (flush_F && (flush_cyc_q != 16'hFFFF)) begin
        flush_cyc_q <= flush_cyc_q + 16'd1;
      end
    end
  end

  assign stall_cyc_cnt = stall_cyc_q;
  assign flush_cyc_cnt = flush_cyc_q;
`endif

endmodule
